// File: rtl/input_recorder.sv
// Record-mode front end for the sequence memory: conditions the switch, key and
// button inputs and writes one {key, sw} word per debounced press at sequential addresses.
module input_recorder #(
   parameter int DEPTH           = 7,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       ADC_CLK_10,
   input  logic       reset_n,
   input  logic       rec_en,
   input  logic       capture_n,
   input  logic [2:0] sw_in,
   input  logic       key_in,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [2:0] count,
   output logic       full
);

   localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       LAST_IDX = 3'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      FULL   = 2'd2
   } state_t;

   logic             cap_meta_r, cap_s_r;
   logic             rec_meta_r, rec_s_r;
   logic             key_meta_r, key_s_r;
   logic [2:0]       sw_meta_r, sw_s_r;
   logic             db_r, db_d_r, press_r;
   logic [CNT_W-1:0] cnt_r;
   logic             rec_d_r, rise_r;

   state_t           state_r, state_s;
   logic             wr_en_r, wr_en_s;
   logic [7:0]       wr_addr_r, wr_addr_s;
   logic [7:0]       wr_data_r, wr_data_s;
   logic [2:0]       count_r, count_s;
   logic             full_r, full_s;
   logic             inc_r, inc_s;
   logic             entry_r, entry_s;

   // Two-flop synchronizers; the button idles released (high)
   always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
         cap_meta_r <= 1'b1;
         cap_s_r    <= 1'b1;
         rec_meta_r <= 1'b0;
         rec_s_r    <= 1'b0;
         key_meta_r <= 1'b0;
         key_s_r    <= 1'b0;
         sw_meta_r  <= 3'b000;
         sw_s_r     <= 3'b000;
      end else begin
         cap_meta_r <= capture_n;
         cap_s_r    <= cap_meta_r;
         rec_meta_r <= rec_en;
         rec_s_r    <= rec_meta_r;
         key_meta_r <= key_in;
         key_s_r    <= key_meta_r;
         sw_meta_r  <= sw_in;
         sw_s_r     <= sw_meta_r;
      end
   end

   // Debouncer plus registered press and record-enable edge detectors
   always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
         db_r    <= 1'b1;
         cnt_r   <= '0;
         db_d_r  <= 1'b1;
         press_r <= 1'b0;
         rec_d_r <= 1'b0;
         rise_r  <= 1'b0;
      end else begin
         if (cap_s_r != db_r) begin
            if (cnt_r == CNT_LAST) begin
               db_r  <= cap_s_r;
               cnt_r <= '0;
            end else begin
               cnt_r <= cnt_r + CNT_W'(1);
            end
         end else begin
            cnt_r <= '0;
         end
         db_d_r  <= db_r;
         press_r <= db_d_r & ~db_r;
         rec_d_r <= rec_s_r;
         rise_r  <= rec_s_r & ~rec_d_r;
      end
   end

   // Next state and next register values; an exit on rec_en low beats a press
   always_comb begin
      state_s   = state_r;
      wr_en_s   = 1'b0;
      wr_addr_s = wr_addr_r;
      wr_data_s = wr_data_r;
      count_s   = count_r;
      full_s    = full_r;
      inc_s     = 1'b0;
      entry_s   = 1'b0;

      // count advances the cycle after the strobe, so the write address is the old count
      if (inc_r) begin
         count_s = count_r + 3'd1;
         full_s  = (count_r == LAST_IDX);
      end else begin
         count_s = count_r;
         full_s  = full_r;
      end

      case (state_r)
         IDLE: begin
            if (rise_r) begin
               state_s = RECORD;
               entry_s = 1'b1;
               count_s = 3'd0;
               full_s  = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         RECORD: begin
            if (!rec_s_r) begin
               state_s = IDLE;
            end else if (inc_r && (count_r == LAST_IDX)) begin
               state_s = FULL;
            end else if (press_r && !entry_r) begin
               wr_en_s   = 1'b1;
               wr_addr_s = {5'b00000, count_r};
               wr_data_s = {4'b0000, key_s_r, sw_s_r};
               inc_s     = 1'b1;
            end else begin
               state_s = RECORD;
            end
         end
         FULL: begin
            if (!rec_s_r) begin
               state_s = IDLE;
            end else begin
               state_s = FULL;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge ADC_CLK_10 or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         wr_en_r   <= 1'b0;
         wr_addr_r <= 8'h00;
         wr_data_r <= 8'h00;
         count_r   <= 3'd0;
         full_r    <= 1'b0;
         inc_r     <= 1'b0;
         entry_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         wr_en_r   <= wr_en_s;
         wr_addr_r <= wr_addr_s;
         wr_data_r <= wr_data_s;
         count_r   <= count_s;
         full_r    <= full_s;
         inc_r     <= inc_s;
         entry_r   <= entry_s;
      end
   end

   assign wr_en   = wr_en_r;
   assign wr_addr = wr_addr_r;
   assign wr_data = wr_data_r;
   assign count   = count_r;
   assign full    = full_r;

endmodule

// File: tb/tb_input_recorder.sv
// Scoreboard bench for input_recorder: expected writes are queued as presses are
// driven and compared against every wr_en strobe the DUT produces.
module tb_input_recorder;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       rec_en;
   logic       capture_n;
   logic [2:0] sw_in;
   logic       key_in;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] count;
   logic       full;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_pulses = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_e;
   logic [2:0]  exp_idx = 3'd0;
   int          exp_count = 0;

   always #5 clk = ~clk;

   input_recorder #(.DEPTH(7), .DEBOUNCE_CYCLES(DB)) dut (
      .ADC_CLK_10 (clk),
      .reset_n    (reset_n),
      .rec_en     (rec_en),
      .capture_n  (capture_n),
      .sw_in      (sw_in),
      .key_in     (key_in),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .count      (count),
      .full       (full)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every strobe must match the oldest queued write
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         n_pulses++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_wr_en", {31'd0, wr_en}, 32'd0);
         end else begin
            exp_e = exp_q.pop_front();
            check_eq("wr_addr", {24'd0, wr_addr}, {24'd0, exp_e[15:8]});
            check_eq("wr_data", {24'd0, wr_data}, {24'd0, exp_e[7:0]});
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [2:0] sw, input logic key, input bit expect_wr);
      sw_in  = sw;
      key_in = key;
      if (expect_wr) begin
         exp_q.push_back({5'd0, exp_idx, 4'd0, key, sw});
         exp_idx++;
         exp_count++;
      end
      capture_n = 1'b0;
      cycles(12);
      capture_n = 1'b1;
      cycles(12);
   endtask

   task automatic check_state(input string tag);
      check_eq({tag, "_count"}, {29'd0, count}, exp_count);
      check_eq({tag, "_full"}, {31'd0, full}, {31'd0, (exp_count == 7)});
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check_eq({tag, "_wr_addr"}, {24'd0, wr_addr}, 32'd0);
      check_eq({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
      check_eq({tag, "_count"}, {29'd0, count}, 32'd0);
      check_eq({tag, "_full"}, {31'd0, full}, 32'd0);
   endtask

   task automatic new_session();
      rec_en = 1'b0;
      cycles(8);
      rec_en = 1'b1;
      cycles(8);
      exp_idx   = 3'd0;
      exp_count = 0;
   endtask

   initial begin
      int lat;
      int p0;

      // reset held with record enabled and button already pressed
      reset_n   = 1'b0;
      rec_en    = 1'b1;
      capture_n = 1'b0;
      sw_in     = 3'b011;
      key_in    = 1'b0;
      #12;
      check_zero("reset");
      exp_q.push_back({8'h00, 8'h03});
      exp_idx   = 3'd1;
      exp_count = 1;
      @(negedge clk);
      reset_n = 1'b1;
      lat = -1;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(posedge clk);
         #1;
         if (wr_en === 1'b1) lat = k;
      end
      check_eq("first_write_latency", lat, 32'd7);
      @(negedge clk);
      capture_n = 1'b1;
      cycles(12);
      check_state("after_first");
      check_eq("drain_1", exp_q.size(), 32'd0);

      // two distinct words
      new_session();
      check_state("session_start");
      press(3'b101, 1'b1, 1'b1);
      check_state("press1");
      press(3'b010, 1'b0, 1'b1);
      check_state("press2");

      // fill to DEPTH, then one ignored press
      for (int i = 0; i < 5; i++) press(3'(i + 3), 1'(i), 1'b1);
      check_state("filled");
      press(3'b111, 1'b1, 1'b0);
      check_state("press_when_full");
      check_eq("drain_2", exp_q.size(), 32'd0);

      // bounce shorter than the debounce window, then a long hold
      new_session();
      capture_n = 1'b0; cycles(3);
      capture_n = 1'b1; cycles(2);
      capture_n = 1'b0; cycles(3);
      capture_n = 1'b1; cycles(20);
      check_state("bounce");
      p0 = n_pulses;
      sw_in  = 3'b110;
      key_in = 1'b0;
      exp_q.push_back({5'd0, exp_idx, 8'h06});
      exp_idx++;
      exp_count++;
      capture_n = 1'b0; cycles(50);
      capture_n = 1'b1; cycles(12);
      check_eq("hold_single_pulse", n_pulses - p0, 32'd1);
      check_state("hold");

      // idle keeps the count and ignores presses; re-entry restarts at address 0
      press(3'b001, 1'b1, 1'b1);
      rec_en = 1'b0;
      cycles(8);
      check_state("idle_hold");
      press(3'b100, 1'b0, 1'b0);
      check_state("idle_press");
      rec_en = 1'b1;
      cycles(8);
      exp_idx   = 3'd0;
      exp_count = 0;
      check_state("reentry");
      press(3'b111, 1'b1, 1'b1);
      check_state("reentry_press");
      check_eq("drain_3", exp_q.size(), 32'd0);

      // press event lands in the same cycle synchronized rec_en falls
      capture_n = 1'b0;
      cycles(5);
      rec_en = 1'b0;
      cycles(12);
      capture_n = 1'b1;
      cycles(12);
      check_state("exit_race");
      press(3'b010, 1'b1, 1'b0);
      check_state("exit_race_idle");

      // reset in the middle of a press that is about to write
      new_session();
      press(3'b011, 1'b0, 1'b1);
      press(3'b101, 1'b0, 1'b1);
      check_state("pre_reset");
      capture_n = 1'b0;
      cycles(6);
      reset_n = 1'b0;
      #1;
      check_zero("mid_reset");
      capture_n = 1'b1;
      cycles(5);
      reset_n = 1'b1;
      exp_idx   = 3'd0;
      exp_count = 0;
      cycles(20);
      check_state("post_reset");
      check_eq("drain_4", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
